mul_result_queue: RTL and testbench

- Issue and retire shell around the 4-stage signed 64x64 multiplier.
- Upstream: accepts valid/ready requests carrying an op code and a tag, and drives the multiplier's strobe and operands.
- Alongside the multiplier, carries op, tag and an unsigned-correction term in a sidecar pipeline.
- Downstream: turns the 128-bit signed product into a 64-bit MUL/MULH/MULHSU/MULHU result, and buffers results in a credit-protected FIFO because the multiplier has no backpressure.

---
 rtl/mul_result_queue.sv | 191 +++++++++++++++++++
 tb/tb_mul_result_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_queue.sv
// Issue/retire shell around a 4-stage signed 64x64 multiplier: sidecar op/tag pipeline,
// MUL/MULH/MULHSU/MULHU result formation and a credit-protected result FIFO.
// Optional same-cycle result bypass when the FIFO is empty: define MUL_RESULT_BYPASS_EN.
module mul_result_queue #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,

  output logic             mul_stb,
  output logic [63:0]      mul_din1,
  output logic [63:0]      mul_din2,
  input  logic             mul_valid,
  input  logic [127:0]     mul_dout,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int unsigned     CntW     = $clog2(DEPTH + 1);
  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

  typedef enum logic [1:0] {OpMul, OpMulh, OpMulhsu, OpMulhu} op_e;

  // ---------------------------------------------------------------------------
  // Issue
  // ---------------------------------------------------------------------------
  logic ready_q;
  logic accept;

  assign accept    = req_valid & ready_q;
  assign req_ready = ready_q;
  assign mul_stb   = accept;
  assign mul_din1  = req_a;
  assign mul_din2  = req_b;

  // Signed product high half plus corr gives the unsigned-operand high half.
  logic        corr_ua;
  logic        corr_ub;
  logic [63:0] corr;

  always_comb begin
    corr_ua = (req_op == OpMulhu);
    corr_ub = (req_op == OpMulhsu) || (req_op == OpMulhu);
    corr    = ((corr_ua && req_a[63]) ? req_b : 64'd0)
            + ((corr_ub && req_b[63]) ? req_a : 64'd0);
  end

  // ---------------------------------------------------------------------------
  // Sidecar pipeline, lock-step with the multiplier
  // ---------------------------------------------------------------------------
  logic [MUL_LAT-1:0] sc_vld_q;
  logic [1:0]         sc_op_q   [MUL_LAT];
  logic [TAG_W-1:0]   sc_tag_q  [MUL_LAT];
  logic [63:0]        sc_corr_q [MUL_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_vld_q <= '0;
    end else begin
      sc_vld_q[0] <= accept;
      for (int i = 1; i < MUL_LAT; i++) begin
        sc_vld_q[i] <= sc_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    sc_op_q[0]   <= req_op;
    sc_tag_q[0]  <= req_tag;
    sc_corr_q[0] <= corr;
    for (int i = 1; i < MUL_LAT; i++) begin
      sc_op_q[i]   <= sc_op_q[i-1];
      sc_tag_q[i]  <= sc_tag_q[i-1];
      sc_corr_q[i] <= sc_corr_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result formation
  // ---------------------------------------------------------------------------
  logic             res_vld;
  logic [63:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  // A mul_valid with no matching sidecar entry is a protocol error; it is dropped so
  // it can never overrun the credit-sized FIFO.
  assign res_vld = mul_valid & sc_vld_q[MUL_LAT-1];
  assign res_tag = sc_tag_q[MUL_LAT-1];

  always_comb begin
    if (sc_op_q[MUL_LAT-1] == OpMul) begin
      res_data = mul_dout[63:0];
    end else begin
      res_data = mul_dout[127:64] + sc_corr_q[MUL_LAT-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO and credits
  // ---------------------------------------------------------------------------
  logic [63:0]      mem_data_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q  [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  credits_q, credits_d;
  logic             fifo_empty;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             rsp_fire;

  assign fifo_empty = (cnt_q == '0);

`ifdef MUL_RESULT_BYPASS_EN
  assign bypass = fifo_empty & res_vld;
`else
  assign bypass = 1'b0;
`endif

  assign rsp_valid = ~fifo_empty | bypass;
  assign rsp_data  = bypass ? res_data : mem_data_q[rptr_q];
  assign rsp_tag   = bypass ? res_tag  : mem_tag_q[rptr_q];
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign push      = res_vld & ~(bypass & rsp_ready);
  assign pop       = ~fifo_empty & rsp_ready;

  always_comb begin
    wptr_d = wptr_q;
    if (push) begin
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    end
    rptr_d = rptr_q;
    if (pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    end

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    credits_d = credits_q;
    case ({accept, rsp_fire})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // ready_q mirrors (credits_q < DEPTH) but is held low while rst is sampled high.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      credits_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      ready_q   <= (credits_d < DepthCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wptr_q] <= res_data;
      mem_tag_q[wptr_q]  <= res_tag;
    end
  end

endmodule

// File: tb/tb_mul_result_queue.sv
// Directed self-checking bench for mul_result_queue with a 4-stage signed multiplier model.
module tb_mul_result_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [3:0]   req_tag;
  logic [63:0]  req_a;
  logic [63:0]  req_b;
  logic         mul_stb;
  logic [63:0]  mul_din1;
  logic [63:0]  mul_din2;
  logic         mul_valid;
  logic [127:0] mul_dout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_data;
  logic [3:0]   rsp_tag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_result_queue #(
    .MUL_LAT(4),
    .DEPTH  (4),
    .TAG_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_tag  (req_tag),
    .req_a    (req_a),
    .req_b    (req_b),
    .mul_stb  (mul_stb),
    .mul_din1 (mul_din1),
    .mul_din2 (mul_din2),
    .mul_valid(mul_valid),
    .mul_dout (mul_dout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_tag  (rsp_tag)
  );

  // 4-stage signed multiplier model, reset together with the DUT
  logic [127:0] prod;
  logic [127:0] mp_q [4];
  logic [3:0]   mv_q;

  assign prod = $signed({{64{mul_din1[63]}}, mul_din1}) * $signed({{64{mul_din2[63]}}, mul_din2});

  always @(posedge clk) begin
    if (rst) mv_q <= '0;
    else     mv_q <= {mv_q[2:0], mul_stb};
    mp_q[0] <= prod;
    mp_q[1] <= mp_q[0];
    mp_q[2] <= mp_q[1];
    mp_q[3] <= mp_q[2];
  end

  assign mul_valid = mv_q[3];
  assign mul_dout  = mp_q[3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [3:0] tag,
                        input logic [63:0] a, input logic [63:0] b);
    req_op    = op;
    req_tag   = tag;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) break;
      step();
    end
    chk("req_accept", req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic take_rsp(input string name, input logic [63:0] exp_data,
                          input logic [3:0] exp_tag);
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) break;
      step();
    end
    chk({name, "_valid"}, rsp_valid, 1);
    chk({name, "_data"}, rsp_data, exp_data);
    chk({name, "_tag"}, rsp_tag, exp_tag);
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int  nxt_rsp;
    int  nxt_req;
    bit  acc;
    bit  saw;

    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_tag   = 4'd0;
    req_a     = 64'd0;
    req_b     = 64'd0;
    rsp_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_stb", mul_stb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    req_valid = 1'b0;
    rst       = 1'b0;
    step();
    chk("post_rst_ready", req_ready, 1);

    // MUL with 5-cycle latency
    do_req(2'd0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    step();
    step();
    step();
    chk("mul_lat_early", rsp_valid, 0);
    step();
    chk("mul_lat_valid", rsp_valid, 1);
    chk("mul_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mul_tag", rsp_tag, 3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("mul_drain", rsp_valid, 0);

    // High-half variants
    do_req(2'd3, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    take_rsp("mulhu", 64'hFFFF_FFFF_FFFF_FFFE, 4'd1);
    do_req(2'd1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    take_rsp("mulh_m1", 64'h0000_0000_0000_0000, 4'd2);
    do_req(2'd2, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    take_rsp("mulhsu", 64'hFFFF_FFFF_FFFF_FFFF, 4'd4);
    do_req(2'd1, 4'd5, 64'h8000_0000_0000_0000, 64'd2);
    take_rsp("mulh_min", 64'hFFFF_FFFF_FFFF_FFFF, 4'd5);

    // Backpressure: six back-to-back MULs (a = tag+10, b = 3), rsp_ready low
    req_op    = 2'd0;
    req_b     = 64'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_tag = 4'(i);
      req_a   = 64'(i + 10);
      chk("bp_accept", req_ready, 1);
      step();
    end
    req_tag = 4'd4;
    req_a   = 64'd14;
    chk("bp_full_ready", req_ready, 0);
    repeat (6) step();
    chk("bp_hold_ready", req_ready, 0);
    chk("bp_head_valid", rsp_valid, 1);
    chk("bp_head_tag", rsp_tag, 0);
    chk("bp_head_data", rsp_data, 64'd30);

    // FIFO full, credits 4: pop and pending request in the same cycle
    rsp_ready = 1'b1;
    chk("fc_no_accept", req_ready, 0);
    step();
    nxt_rsp = 1;
    nxt_req = 4;
    chk("fc_ready_after_pop", req_ready, 1);

    for (int c = 0; c < 60 && nxt_rsp < 6; c++) begin
      if (rsp_valid && rsp_ready) begin
        chk("order_tag", rsp_tag, 128'(nxt_rsp));
        chk("order_data", rsp_data, 128'(3 * (nxt_rsp + 10)));
        nxt_rsp++;
      end
      acc = req_valid && req_ready;
      step();
      if (acc) begin
        nxt_req++;
        if (nxt_req == 6) begin
          req_valid = 1'b0;
        end else begin
          req_tag = 4'(nxt_req);
          req_a   = 64'(nxt_req + 10);
        end
      end
    end
    chk("order_rsp_count", 128'(nxt_rsp), 6);
    chk("order_req_count", 128'(nxt_req), 6);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    chk("order_empty", rsp_valid, 0);

    // Reset mid-flight: three accepts, reset two cycles later
    req_op    = 2'd1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_tag = 4'(8 + i);
      req_a   = 64'(i + 1);
      chk("mf_accept", req_ready, 1);
      step();
    end
    req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("mf_rst_ready", req_ready, 0);
    chk("mf_rst_rsp", rsp_valid, 0);
    rst = 1'b0;
    step();
    chk("mf_ready_after", req_ready, 1);
    rsp_ready = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      saw |= rsp_valid;
      step();
    end
    chk("mf_no_rsp", saw, 0);
    rsp_ready = 1'b0;

    // Credits restarted at zero: exactly four accepts before stalling
    req_op    = 2'd0;
    req_b     = 64'd1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_tag = 4'(12 + i);
      req_a   = 64'(12 + i);
      chk("mf_credit_accept", req_ready, 1);
      step();
    end
    chk("mf_credit_full", req_ready, 0);
    req_valid = 1'b0;
    take_rsp("mf_r12", 64'd12, 4'd12);
    take_rsp("mf_r13", 64'd13, 4'd13);
    take_rsp("mf_r14", 64'd14, 4'd14);
    take_rsp("mf_r15", 64'd15, 4'd15);
    step();
    chk("mf_final_empty", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
